// File: rtl/multi_timer_if.sv
// -----------------------------------------------------------------------------
// multi_timer_if
//   Chip-select / address-strobe peripheral bus used by the multi_timer.
//   rw encoding: 1 = read, 0 = write.
//
//   cs_      chip select, active low            (master -> slave)
//   as_      address strobe, active low         (master -> slave)
//   rw       1 = read, 0 = write                (master -> slave)
//   addr     [3:2] channel index, [1:0] register (master -> slave)
//   wr_data  write data                         (master -> slave)
//   rd_data  registered read data               (slave -> master)
//   rdy_     ready, active low                  (slave -> master)
// -----------------------------------------------------------------------------
interface multi_timer_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );
endinterface

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   NUM_CH independent timers behind one bus-slave port. Each channel has a
//   CTRL (start, mode, irq_en, prescale), INTR (sticky irq, write-1-clear),
//   EXPR (expiry value) and COUNTER register. A channel counts on every tick
//   while started; when the count equals EXPR on a tick it clears, raises its
//   irq, and in one-shot mode stops itself.
//
//   Optional feature macro: TIMER_PRESCALER_EN
//     defined   - per-channel prescaler divides the tick rate by prescale+1
//     undefined - tick on every clock while started; prescale reads 0
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    multi_timer_if.slave (cs_, as_, rw, addr, wr_data, rd_data, rdy_)
//   irq    OR over channels of (irq & irq_en), from registered state only
// -----------------------------------------------------------------------------
module multi_timer #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  multi_timer_if.slave   bus,
  output logic           irq
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_INTR    = 2'd1,
    REG_EXPR    = 2'd2,
    REG_COUNTER = 2'd3
  } reg_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       access;
  logic       rd_acc;
  logic       wr_acc;
  logic [1:0] ch_idx;
  reg_e       reg_sel;

  assign access  = !bus.cs_ && !bus.as_;
  assign rd_acc  = access && bus.rw;
  assign wr_acc  = access && !bus.rw;
  assign ch_idx  = bus.addr[3:2];
  assign reg_sel = reg_e'(bus.addr[1:0]);

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] irq_flag;
  logic [CNT_W-1:0]  expr_val [NUM_CH];
  logic [CNT_W-1:0]  counter  [NUM_CH];

  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_intr;
  logic [NUM_CH-1:0] wr_expr;
  logic [NUM_CH-1:0] wr_cnt;

  // Channel indices that do not exist never match, so such writes are dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ctrl = '0;
    wr_intr = '0;
    wr_expr = '0;
    wr_cnt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_acc && (ch_idx == 2'(i))) begin
        wr_ctrl[i] = (reg_sel == REG_CTRL);
        wr_intr[i] = (reg_sel == REG_INTR);
        wr_expr[i] = (reg_sel == REG_EXPR);
        wr_cnt[i]  = (reg_sel == REG_COUNTER);
      end
    end
  end

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale [NUM_CH];
  logic [PRESCALE_W-1:0] pcnt     [NUM_CH];

  always_comb begin
    tick = '0;
    for (int i = 0; i < NUM_CH; i++)
      tick[i] = start[i] && (pcnt[i] == prescale[i]);
  end

  // pcnt restarts from 0 on any CTRL write so the first tick after setting
  // start lands exactly prescale+1 clocks later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prescale[i] <= '0;
        pcnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ctrl[i]) begin
          prescale[i] <= bus.wr_data[8 +: PRESCALE_W];
          pcnt[i]     <= '0;
        end else if (!start[i] || tick[i]) begin
          pcnt[i] <= '0;
        end else begin
          pcnt[i] <= pcnt[i] + PRESCALE_W'(1);
        end
      end
    end
  end
`else
  assign tick = start;
`endif

  always_comb begin
    expire = '0;
    for (int i = 0; i < NUM_CH; i++)
      expire[i] = tick[i] && (counter[i] == expr_val[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start    <= '0;
      mode     <= '0;
      irq_en   <= '0;
      irq_flag <= '0;
      // NOTE: these arrays are a handful of flops, not a RAM, so they take the
      // asynchronous reset like any other register.
      for (int i = 0; i < NUM_CH; i++) begin
        expr_val[i] <= '0;
        counter[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (wr_ctrl[i]) begin
          start[i]  <= bus.wr_data[0];
          mode[i]   <= bus.wr_data[1];
          irq_en[i] <= bus.wr_data[2];
        end else if (expire[i] && !mode[i]) begin
          start[i] <= 1'b0;
        end

        // A new expiry wins over a simultaneous software clear.
        if (expire[i])
          irq_flag[i] <= 1'b1;
        else if (wr_intr[i] && bus.wr_data[0])
          irq_flag[i] <= 1'b0;

        if (wr_expr[i])
          expr_val[i] <= bus.wr_data[CNT_W-1:0];

        if (wr_cnt[i])
          counter[i] <= bus.wr_data[CNT_W-1:0];
        else if (expire[i])
          counter[i] <= '0;
        else if (tick[i])
          counter[i] <= counter[i] + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and bus response
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 2'(i)) begin
        case (reg_sel)
          REG_CTRL: begin
            rd_word[2:0] = {irq_en[i], mode[i], start[i]};
`ifdef TIMER_PRESCALER_EN
            rd_word[8 +: PRESCALE_W] = prescale[i];
`endif
          end
          REG_INTR:    rd_word[0] = irq_flag[i];
          REG_EXPR:    rd_word    = 32'(expr_val[i]);
          REG_COUNTER: rd_word    = 32'(counter[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_data <= '0;
      bus.rdy_    <= 1'b1;
    end else begin
      bus.rdy_    <= !access;
      bus.rd_data <= rd_acc ? rd_word : '0;
    end
  end

  assign irq = |(irq_flag & irq_en);

  // Write data bits above the narrowest field are architecturally ignored.
  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data;

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel successor to the single-channel bus timer. It provides NUM_CH independent timers, each with a configurable width, an optional clock prescaler, one-shot or periodic mode, and a per-channel interrupt enable. All channels share one bus-slave port on the standard chip-select/address-strobe bus, with the same rdy_/rd_data handshake as the other peripherals. A single combined irq goes to the interrupt controller.

## Interface
- NUM_CH, 2, number of channels, 1..4
- CNT_W, 32, counter and expiry width, 1..32
- PRESCALE_W, 8, prescaler field width, 1..16
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cs_  input  1  chip select, active low
- as_  input  1  address strobe, active low
- rw  input  1  READ/WRITE select (codebase encoding)
- addr  input  4  [3:2] channel index, [1:0] register
- wr_data  input  32  write data
- rd_data  output  32  registered read data
- rdy_  output  1  ready, active low
- irq  output  1  OR over channels of (irq_n & irq_en_n)

## Operation
- Access is valid when cs_ and as_ are both low. Registers per channel:
  - addr[1:0] = 0, CTRL: bit0 start, bit1 mode (0 = one-shot, 1 = periodic), bit2 irq_en, bits[8+PRESCALE_W-1:8] prescale.
  - addr[1:0] = 1, INTR: bit0 irq. Writing 1 clears it; writing 0 has no effect.
  - addr[1:0] = 2, EXPR: expiry value, CNT_W bits.
  - addr[1:0] = 3, COUNTER: current count, CNT_W bits.
- Field handling: reads zero-extend every field to 32 bits; writes truncate to field width.
- Channel index >= NUM_CH: read returns 0, write is ignored, rdy_ still responds.
- Prescaler, per channel:
  - pcnt runs only while start = 1; tick = start & (pcnt == prescale).
  - On tick, pcnt wraps to 0; otherwise it increments.
  - pcnt is forced to 0 while start = 0 and on any CTRL write.
- Expiry: expire = tick & (counter == expr_val).
  - On expire: counter <= 0 and irq <= 1. In one-shot mode start <= 0 as well.
  - On a tick without expire: counter <= counter + 1, modulo 2^CNT_W.
- Period is (expr_val+1)*(prescale+1) clocks. expr_val = 0 with prescale = 0 expires on every clock.
- Priority rules, per channel, per cycle:
  - Counter: COUNTER write > expire clear > increment.
  - start: CTRL write > one-shot auto-stop.
  - irq: expire set > INTR write-1 clear.
- Channels are fully independent. A write touches only the addressed channel.

## Timing
- Reset values (asynchronous): rd_data = 0, rdy_ = 1, irq = 0. Every channel: start = 0, mode = 0, irq_en = 0, prescale = 0, irq = 0, expr_val = 0, counter = 0, pcnt = 0.
- Handshake:
  - rdy_ goes low on the edge after a valid access and stays low for each cycle the access is held.
  - rd_data is valid in that same cycle and is 0 in any cycle without a valid read.
- Register writes take effect on the edge that samples the access.
- irq goes high on the edge after the expire cycle; it is registered, with no combinational path from the bus.
- A CTRL write setting start = 1 gives the first tick prescale+1 clocks later.
- Reset asserted mid-count immediately clears all state. Counting resumes only after software sets start again.

## Configuration
- TIMER_PRESCALER_EN
  - Defined: the prescaler operates as described.
  - Undefined: no pcnt logic; tick = start every clock; the prescale field is not stored, reads 0 and ignores writes.

## Test plan
- Reset: assert reset mid-count -> all outputs and registers read 0, rdy_ = 1.
- One-shot, channel 0: EXPR = 5, prescale = 0, CTRL = 0x5 -> irq rises 6 clocks after start; start reads 0; COUNTER reads 0 and stays 0.
- Periodic with prescaler, channel 1: EXPR = 3, prescale = 2, CTRL = 0x207 -> irq_1 sets every 12 clocks; writing INTR = 1 clears it; counter keeps cycling 0..3.
- Simultaneous events: INTR clear in the expire cycle -> irq stays 1. COUNTER write of 9 in the expire cycle -> counter = 9, irq = 1.
- Masking and isolation: both channels expire, irq_en only on channel 1 -> irq follows channel 1 only. Access to channel 3 with NUM_CH = 2 -> reads 0, rdy_ low.
- Wrap and width: CNT_W = 8, EXPR = 0xFF, COUNTER written 0x1FE -> reads 0xFE; expires after 2 ticks. With TIMER_PRESCALER_EN undefined, prescale reads 0.
